// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, address-decode select type and byte-mask helper for the data memory
package dmem_pkg;

    localparam int DMEM_DATA_W  = 64;
    localparam int DMEM_WORDS   = 8192;
    localparam int DMEM_ADDR_W  = 13;
    localparam int DMEM_SW_IDX  = 21;
    localparam int DMEM_LED_IDX = 22;
    localparam int DMEM_IRQ_IDX = 23;

    // Widest supported data word; callers size-cast in and out of the mask helper
    localparam int BE_MAX   = 128;
    localparam int MASK_MAX = 8 * BE_MAX;

    typedef enum logic [2:0] {SEL_RAM, SEL_SW, SEL_LED, SEL_IRQ, SEL_OOR} mmio_sel_t;

    function automatic logic [MASK_MAX-1:0] byte_mask(input logic [BE_MAX-1:0] be);
        logic [MASK_MAX-1:0] m;
        for (int i = 0; i < BE_MAX; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parametrised-width two-flop synchroniser with asynchronous active-low reset
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: MEM-stage data RAM with registered reads, byte-masked writes, switch/LED MMIO
// and an optional switch-change interrupt enabled by defining DMEM_SW_IRQ_EN
module data_memory_mmio
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int WORDS   = DMEM_WORDS,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int SW_W    = 18,
    parameter int LED_W   = 27,
    parameter int SW_IDX  = DMEM_SW_IDX,
    parameter int LED_IDX = DMEM_LED_IDX,
    parameter int IRQ_IDX = DMEM_IRQ_IDX
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [63:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [SW_W-1:0]     switches,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                addr_error,
    output logic [LED_W-1:0]    leds,
    output logic                irq
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_addr_error;
    logic [LED_W-1:0]  r_led;
    logic [SW_W-1:0]   w_sw_sync;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_rdata;
    logic              w_in_range;
    mmio_sel_t         w_sel;

    sync_2ff #(.W(SW_W)) u_sw_sync (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_d       (switches),
        .o_q       (w_sw_sync)
    );

    assign w_in_range = address < 64'(WORDS);
    assign w_idx      = address[ADDR_W-1:0];
    assign w_mask     = DATA_W'(byte_mask(BE_MAX'(byte_en)));

`ifdef DMEM_SW_IRQ_EN
    logic [SW_W-1:0] r_sw_prev;
    logic [SW_W-1:0] r_sw_status;
    logic [SW_W-1:0] w_sw_clr;
    logic [SW_W-1:0] w_status_nxt;
    logic            r_irq;

    assign w_sw_clr     = (mem_write && w_sel == SEL_IRQ) ? write_data[SW_W-1:0] & w_mask[SW_W-1:0] : '0;
    assign w_status_nxt = (r_sw_status & ~w_sw_clr) | (w_sw_sync ^ r_sw_prev);

    // Sticky change flags: W1C clears first so a same-cycle edge still sets the bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_prev   <= '0;
            r_sw_status <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_sw_prev   <= w_sw_sync;
            r_sw_status <= w_status_nxt;
            r_irq       <= |w_status_nxt;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Range check first; only in-range addresses are decoded by their low index bits
    always_comb begin
        w_sel = SEL_RAM;
        if (!w_in_range) w_sel = SEL_OOR;
        else if (w_idx == ADDR_W'(SW_IDX)) w_sel = SEL_SW;
        else if (w_idx == ADDR_W'(LED_IDX)) w_sel = SEL_LED;
`ifdef DMEM_SW_IRQ_EN
        else if (w_idx == ADDR_W'(IRQ_IDX)) w_sel = SEL_IRQ;
`endif
    end

    // Load source select; narrow MMIO registers are zero-extended
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_RAM: w_rdata = r_mem[w_idx];
            SEL_SW:  w_rdata = DATA_W'(w_sw_sync);
            SEL_LED: w_rdata = DATA_W'(r_led);
`ifdef DMEM_SW_IRQ_EN
            SEL_IRQ: w_rdata = DATA_W'(r_sw_status);
`endif
            default: w_rdata = '0;
        endcase
    end

    // Byte-masked RAM store; the array is intentionally not reset
    always_ff @(posedge clock) begin
        if (mem_write && w_sel == SEL_RAM) r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (write_data & w_mask);
    end

    // Registered load result; the read samples the array before a same-cycle store lands
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_read_valid <= mem_read;
            r_addr_error <= (mem_read || mem_write) && w_sel == SEL_OOR;
            if (mem_read) r_read_data <= w_rdata;
        end
    end

    // LED register takes the byte-masked low LED_W bits of a store
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_led <= '0;
        else if (mem_write && w_sel == SEL_LED) r_led <= (r_led & ~w_mask[LED_W-1:0]) | (write_data[LED_W-1:0] & w_mask[LED_W-1:0]);
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign addr_error = r_addr_error;
    assign leds       = r_led;

endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: scoreboard-based self-checking bench for data_memory_mmio
module tb_data_memory_mmio;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] address = '0;
    logic [63:0] write_data = '0;
    logic [7:0]  byte_en = '0;
    logic [17:0] switches = '0;
    logic [63:0] read_data;
    logic        read_valid;
    logic        addr_error;
    logic [26:0] leds;
    logic        irq;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_d;

    data_memory_mmio dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .byte_en    (byte_en),
        .switches   (switches),
        .read_data  (read_data),
        .read_valid (read_valid),
        .addr_error (addr_error),
        .leds       (leds),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; presents one access for one clock edge, returns at the next negedge.
    // Expected load data is pushed to the scoreboard when the read is issued.
    task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [63:0] wd, input logic [7:0] be, input logic [63:0] exp);
        mem_read = rd; mem_write = wr; address = a; write_data = wd; byte_en = be;
        if (rd) sb.push_back(exp);
        @(negedge clock);
        mem_read = 1'b0; mem_write = 1'b0; byte_en = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_chk++; if (read_data !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", read_data); end
        n_chk++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", read_valid); end
        n_chk++; if (addr_error !== 1'b0) begin n_fail++; $display("FAIL reset_aerr: got %b want 0", addr_error); end
        n_chk++; if (leds !== 27'h0) begin n_fail++; $display("FAIL reset_leds: got %h want 0", leds); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        access(0, 1, 64'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0);
        n_chk++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", read_valid); end
        access(1, 0, 64'd5, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
        exp_d = sb.pop_front();
        n_chk++; if (read_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b want 1", read_valid); end
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL rd_data: got %h want %h", read_data, exp_d); end
        @(negedge clock);
        n_chk++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b want 0", read_valid); end
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL rdata_hold: got %h want %h", read_data, exp_d); end
    endtask

    task automatic test_byte_en();
        access(0, 1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0);
        access(0, 1, 64'd5, 64'h0, 8'h00, 64'h0);
        access(1, 0, 64'd5, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d || read_valid !== 1'b1) begin n_fail++; $display("FAIL byte_en: got %h/%b want %h/1", read_data, read_valid, exp_d); end
        access(0, 1, 64'd6, 64'hA1B2_C3D4_E5F6_0718, 8'hFF, 64'h0);
        access(0, 1, 64'd6, 64'h0000_0000_0000_0000, 8'h81, 64'h0);
        access(1, 0, 64'd6, 64'h0, 8'h00, 64'h00B2_C3D4_E5F6_0700);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL byte_en_edges: got %h want %h", read_data, exp_d); end
    endtask

    task automatic test_read_first();
        access(1, 1, 64'd5, 64'h0000_0000_0000_00AA, 8'hFF, 64'h0123_4567_FFFF_FFFF);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL read_first_old: got %h want %h", read_data, exp_d); end
        access(1, 0, 64'd5, 64'h0, 8'h00, 64'h0000_0000_0000_00AA);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL read_first_new: got %h want %h", read_data, exp_d); end
    endtask

    task automatic test_mmio();
        switches = 18'h2A5A5;
        repeat (3) @(negedge clock);
        access(1, 0, 64'd21, 64'h0, 8'h00, 64'h2A5A5);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL sw_read: got %h want %h", read_data, exp_d); end
        access(0, 1, 64'd21, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0);
        access(1, 0, 64'd21, 64'h0, 8'h00, 64'h2A5A5);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL sw_readonly: got %h want %h", read_data, exp_d); end
        access(0, 1, 64'd22, 64'h7FF_FFFF, 8'hFF, 64'h0);
        n_chk++; if (leds !== 27'h7FF_FFFF) begin n_fail++; $display("FAIL led_write: got %h want 7ffffff", leds); end
        access(0, 1, 64'd22, 64'h0, 8'h01, 64'h0);
        n_chk++; if (leds !== 27'h7FF_FF00) begin n_fail++; $display("FAIL led_mask: got %h want 7ffff00", leds); end
        access(0, 1, 64'd22, 64'hFFFF_FFFF_F123_4567, 8'hFF, 64'h0);
        access(1, 0, 64'd22, 64'h0, 8'h00, 64'h0000_0000_0123_4567);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL led_readback: got %h want %h", read_data, exp_d); end
        n_chk++; if (leds !== 27'h123_4567) begin n_fail++; $display("FAIL led_trunc: got %h want 1234567", leds); end
    endtask

    task automatic test_out_of_range();
        access(0, 1, 64'd0, 64'h0000_0000_0000_1111, 8'hFF, 64'h0);
        access(1, 1, 64'd8192, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0);
        exp_d = sb.pop_front();
        n_chk++; if (addr_error !== 1'b1 || read_valid !== 1'b1) begin n_fail++; $display("FAIL oor_flags: got aerr=%b rv=%b want 1/1", addr_error, read_valid); end
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL oor_rdata: got %h want %h", read_data, exp_d); end
        access(1, 0, 64'd0, 64'h0, 8'h00, 64'h0000_0000_0000_1111);
        exp_d = sb.pop_front();
        n_chk++; if (addr_error !== 1'b0) begin n_fail++; $display("FAIL oor_pulse: got %b want 0", addr_error); end
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL oor_no_ram_change: got %h want %h", read_data, exp_d); end
        access(0, 1, 64'h1_0000_0005, 64'h0, 8'hFF, 64'h0);
        n_chk++; if (addr_error !== 1'b1 || read_valid !== 1'b0) begin n_fail++; $display("FAIL oor_high_write: got aerr=%b rv=%b want 1/0", addr_error, read_valid); end
        access(1, 0, 64'd5, 64'h0, 8'h00, 64'h0000_0000_0000_00AA);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL oor_high_no_alias: got %h want %h", read_data, exp_d); end
    endtask

    task automatic test_irq();
`ifdef DMEM_SW_IRQ_EN
        access(0, 1, 64'd23, 64'h3FFFF, 8'hFF, 64'h0);
        repeat (2) @(negedge clock);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared_all: got %b want 0", irq); end
        switches = switches ^ 18'h8;
        repeat (5) @(negedge clock);
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
        access(1, 0, 64'd23, 64'h0, 8'h00, 64'h8);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL irq_status: got %h want %h", read_data, exp_d); end
        access(0, 1, 64'd23, 64'h8, 8'hFF, 64'h0);
        @(negedge clock);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", irq); end
`else
        switches = switches ^ 18'h8;
        repeat (5) @(negedge clock);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b want 0", irq); end
        access(0, 1, 64'd23, 64'h0000_0000_0000_0055, 8'hFF, 64'h0);
        access(1, 0, 64'd23, 64'h0, 8'h00, 64'h0000_0000_0000_0055);
        exp_d = sb.pop_front();
        n_chk++; if (read_data !== exp_d) begin n_fail++; $display("FAIL irq_idx_ram: got %h want %h", read_data, exp_d); end
`endif
    endtask

    task automatic test_reset_mid_read();
        mem_read = 1'b1; address = 64'd5;
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (read_data !== 64'h0 || leds !== 27'h0) begin n_fail++; $display("FAIL async_reset: got rd=%h leds=%h want 0/0", read_data, leds); end
        @(negedge clock);
        n_chk++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop_read: got %b want 0", read_valid); end
        mem_read = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        n_chk++; if (read_valid !== 1'b0 || read_data !== 64'h0) begin n_fail++; $display("FAIL post_reset: got rv=%b rd=%h want 0/0", read_valid, read_data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_en();
        test_read_first();
        test_mmio();
        test_out_of_range();
        test_irq();
        test_reset_mid_read();
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
